// File: rtl/lcd_status_display_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_status_display_if
// Description : Handshake bundle between the status-display text driver and
//               the character-LCD controller (iDATA/iRS/iStart/oDone).
//               master = text driver, slave = LCD controller.
//   oLCD_DATA  [7:0] byte to the controller (driven by master)
//   oLCD_RS          0 = command, 1 = character (driven by master)
//   oLCD_START       request to the controller (driven by master)
//   iLCD_DONE        controller completion pulse/level (driven by slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_status_display_if;
  logic [7:0] oLCD_DATA;
  logic       oLCD_RS;
  logic       oLCD_START;
  logic       iLCD_DONE;

  modport master (
    output oLCD_DATA,
    output oLCD_RS,
    output oLCD_START,
    input  iLCD_DONE
  );

  modport slave (
    input  oLCD_DATA,
    input  oLCD_RS,
    input  oLCD_START,
    output iLCD_DONE
  );
endinterface : lcd_status_display_if
`default_nettype wire

// File: rtl/lcd_status_display.sv
`default_nettype none
// ============================================================================
// Module      : lcd_status_display
// Description : Host-side text driver for the 16x2 elevator-panel LCD. Writes
//               an init + two-line frame after reset, then redraws both lines
//               (refresh frame) whenever the displayed inputs change.
//               Line 1: floor name, line 2: door state + direction glyph.
// Ports       :
//   iCLK            system clock
//   iRST_N          asynchronous active-low reset
//   iFLOOR  [FW-1:0] current floor index
//   iDOOR           1 = closed, 0 = open
//   iDIR    [1:0]   01 = up, 10 = down, 00/11 = stopped
//   lcd             controller handshake (lcd_status_display_if.master)
//   oBUSY           high while a frame is being written
// Config      : define LCD_DIR_EN to render the direction glyph in line 2
//               column 15 and to let iDIR trigger redraws. Undefined: column
//               15 is a space and iDIR is ignored.
// Notes       : DLY_CYCLES must be >= 1.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_status_display #(
  parameter int NUM_FLOORS = 5,
  parameter int FLOOR_W    = 3,
  parameter int DLY_CYCLES = 262142,
  parameter int DLY_W      = 18
) (
  input  wire                  iCLK,
  input  wire                  iRST_N,
  input  wire [FLOOR_W-1:0]    iFLOOR,
  input  wire                  iDOOR,
  input  wire [1:0]            iDIR,
  lcd_status_display_if.master lcd,
  output logic                 oBUSY
);

  localparam int         SNAP_W      = FLOOR_W + 3;
  localparam logic [5:0] IDX_REFRESH = 6'd4;   // first entry of a refresh frame (0x080)
  localparam logic [5:0] IDX_LINE2   = 6'd21;  // 0x0C0 entry
  localparam logic [5:0] IDX_LAST    = 6'd37;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DLY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_DELAY = 3'd3,
    S_NEXT  = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Registered state and their next-state values
  // --------------------------------------------------------------------------
  state_t             state,       state_nxt;
  logic [5:0]         index,       index_nxt;
  logic [DLY_W-1:0]   dly_cnt,     dly_nxt;
  logic [7:0]         data_q,      data_nxt;
  logic               rs_q,        rs_nxt;
  logic               start_q,     start_nxt;
  logic               busy_q,      busy_nxt;
  logic [SNAP_W-1:0]  snap,        snap_nxt;
  logic               pending,     pending_nxt;
  // Marks that the next LOAD is the first entry of a frame, where the
  // snapshot is taken. Set by reset (init frame) and by IDLE->LOAD.
  logic               snap_due,    snap_due_nxt;

  // --------------------------------------------------------------------------
  // Live input vector compared against the snapshot
  // --------------------------------------------------------------------------
  logic [1:0]         dir_live;
  logic [SNAP_W-1:0]  live;
  logic               live_differs;

`ifdef LCD_DIR_EN
  assign dir_live = iDIR;
`else
  // Direction is masked out so it can neither be shown nor trigger a redraw.
  assign dir_live = iDIR & 2'b00;
`endif

  assign live         = {iFLOOR, iDOOR, dir_live};
  assign live_differs = (live != snap);

  // --------------------------------------------------------------------------
  // Text rendering from the snapshot
  // --------------------------------------------------------------------------
  logic [31:0]  floor_num;
  logic [7:0]   floor8;
  logic [7:0]   tens;
  logic [7:0]   ones;
  logic [127:0] line1;
  logic [127:0] line2;
  logic [7:0]   glyph;

  assign floor_num = 32'(snap[SNAP_W-1:3]);
  assign floor8    = floor_num[7:0];
  assign tens      = floor8 / 8'd10;
  assign ones      = floor8 % 8'd10;

  always_comb begin
    line1 = "Floor ??        ";
    if (floor_num == 32'd0) begin
      line1 = "Ground Floor    ";
    end else if (floor_num == 32'(NUM_FLOORS - 1)) begin
      line1 = "Roof            ";
    end else if (floor_num < 32'(NUM_FLOORS)) begin
      if (tens == 8'd0) begin
        line1 = {"Floor ", 8'h30 + ones, "         "};
      end else begin
        line1 = {"Floor ", 8'h30 + tens, 8'h30 + ones, "        "};
      end
    end
  end

`ifdef LCD_DIR_EN
  always_comb begin
    unique case (snap[1:0])
      2'b01:   glyph = "^";
      2'b10:   glyph = "v";
      default: glyph = " ";
    endcase
  end
`else
  assign glyph = " ";
`endif

  assign line2 = snap[2] ? {"Door Close     ", glyph} : {"Door Open      ", glyph};

  // --------------------------------------------------------------------------
  // Entry table: 0..3 init, 4 = line-1 address, 5..20 line 1,
  //              21 = line-2 address, 22..37 line 2
  // --------------------------------------------------------------------------
  logic [3:0] col1;
  logic [3:0] col2;
  logic [8:0] entry;  // {rs, data}

  assign col1 = 4'(index - 6'd5);
  assign col2 = 4'(index - 6'd22);

  always_comb begin
    entry = 9'h120;
    if (index < IDX_REFRESH) begin
      unique case (index[1:0])
        2'd0:    entry = 9'h038;  // 8-bit bus, 2 lines
        2'd1:    entry = 9'h00C;  // display on, cursor off
        2'd2:    entry = 9'h001;  // clear
        default: entry = 9'h006;  // entry mode: increment
      endcase
    end else if (index == IDX_REFRESH) begin
      entry = 9'h080;
    end else if (index < IDX_LINE2) begin
      entry = {1'b1, line1[{4'(4'd15 - col1), 3'b000} +: 8]};
    end else if (index == IDX_LINE2) begin
      entry = 9'h0C0;
    end else begin
      entry = {1'b1, line2[{4'(4'd15 - col2), 3'b000} +: 8]};
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    index_nxt    = index;
    dly_nxt      = dly_cnt;
    data_nxt     = data_q;
    rs_nxt       = rs_q;
    start_nxt    = start_q;
    busy_nxt     = busy_q;
    snap_nxt     = snap;
    pending_nxt  = pending;
    snap_due_nxt = snap_due;

    // Any change seen while a frame is in flight earns one follow-up frame.
    if ((state != S_IDLE) && live_differs) begin
      pending_nxt = 1'b1;
    end

    unique case (state)
      S_IDLE: begin
        if (live_differs || pending) begin
          state_nxt    = S_LOAD;
          index_nxt    = IDX_REFRESH;
          snap_due_nxt = 1'b1;
        end
      end

      S_LOAD: begin
        {rs_nxt, data_nxt} = entry;
        start_nxt          = 1'b1;
        busy_nxt           = 1'b1;
        state_nxt          = S_WAIT;
        // Snapshot overrides any pending set in this same cycle: the frame
        // now starting already shows the latest inputs.
        if (snap_due) begin
          snap_nxt     = live;
          pending_nxt  = 1'b0;
          snap_due_nxt = 1'b0;
        end
      end

      S_WAIT: begin
        if (lcd.iLCD_DONE) begin
          start_nxt = 1'b0;
          dly_nxt   = '0;
          state_nxt = S_DELAY;
        end
      end

      S_DELAY: begin
        if (dly_cnt == DLY_LAST) begin
          state_nxt = S_NEXT;
        end else begin
          dly_nxt = dly_cnt + 1'b1;
        end
      end

      S_NEXT: begin
        if (index == IDX_LAST) begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
        end else begin
          index_nxt = index + 6'd1;
          state_nxt = S_LOAD;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register. Reset lands in LOAD at index 0 so the init frame's first
  // command is driven on the first edge after release.
  // --------------------------------------------------------------------------
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= S_LOAD;
      index    <= '0;
      dly_cnt  <= '0;
      data_q   <= '0;
      rs_q     <= 1'b0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      snap     <= '0;
      pending  <= 1'b0;
      snap_due <= 1'b1;
    end else begin
      state    <= state_nxt;
      index    <= index_nxt;
      dly_cnt  <= dly_nxt;
      data_q   <= data_nxt;
      rs_q     <= rs_nxt;
      start_q  <= start_nxt;
      busy_q   <= busy_nxt;
      snap     <= snap_nxt;
      pending  <= pending_nxt;
      snap_due <= snap_due_nxt;
    end
  end

  assign lcd.oLCD_DATA  = data_q;
  assign lcd.oLCD_RS    = rs_q;
  assign lcd.oLCD_START = start_q;
  assign oBUSY          = busy_q;

endmodule : lcd_status_display
`default_nettype wire
